// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-port arbiter in front of a single-ported data memory with a
// combinational read path.
//   port 0 : CPU memory stage (default priority)
//   port 1 : DMA / loader (anti-starvation via wait1, optional lock)
//
// Handshake: a requester raises reqN with weN/addrN/wdataN/beN and holds
// them until gntN is high. gntN is combinational. The access completes at
// the rising edge that ends the grant cycle. rvalidN pulses for one cycle
// after that edge with rdataN/rerrN. A new request may be presented in the
// cycle right after the grant.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   req*/we*/addr*/wdata*/be*    request side of each port
//   lock1                        port 1 asks to keep ownership
//   gnt*, rdata*, rvalid*, rerr* grant and registered response per port
//   stall0                       req0 & ~gnt0 for the hazard unit
//   mem_we/mem_a/mem_wd/mem_be   memory command from the granted port
//   mem_rd                       combinational memory read data
//   dbg_state                    current FSM state (0 = ARB, 1 = LOCK1)
//
// be codes: 1111 word, 0001 byte, 0011 half; bit 3 set on a sub-word read
// selects sign extension (1001 signed byte, 1011 signed half).
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int MAX_LOCK = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [3:0]  be0,
  input  logic [3:0]  be1,
  input  logic        lock1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic        rerr0,
  output logic        rerr1,
  output logic        stall0,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rd,
  output logic        dbg_state
);

  localparam logic [0:0] S_ARB   = 1'b0;
  localparam logic [0:0] S_LOCK1 = 1'b1;

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int LOCK_W = (MAX_LOCK < 2) ? 1 : $clog2(MAX_LOCK + 1);

  logic [0:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait1_q, wait1_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic              rerr0_q, rerr0_d, rerr1_q, rerr1_d;
  logic [31:0]       rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic ill0, ill1;
  logic lock_exit;

  // Legal code table plus alignment: words need a[1:0]=0, halves need a[0]=0.
  function automatic logic is_illegal(input logic we, input logic [3:0] be,
                                      input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    case (be)
      4'b1111: ok = (a == 2'b00);
      4'b0001: ok = 1'b1;
      4'b0011: ok = ~a[0];
      4'b1001: ok = ~we;
      4'b1011: ok = ~we & ~a[0];
      default: ok = 1'b0;
    endcase
    return ~ok;
  endfunction

  // Little-endian lane select of the word returned by memory.
  function automatic logic [31:0] load_ext(input logic [31:0] rd,
                                           input logic [1:0] a,
                                           input logic [3:0] be);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (be)
      4'b1111: r = rd;
      4'b0001: r = {24'b0, b};
      4'b1001: r = {{24{b[7]}}, b};
      4'b0011: r = {16'b0, h};
      4'b1011: r = {{16{h[15]}}, h};
      default: r = 32'b0;
    endcase
    return r;
  endfunction

  assign ill0 = is_illegal(we0, be0, addr0[1:0]);
  assign ill1 = is_illegal(we1, be1, addr1[1:0]);

  // Grant: nothing while reset is asserted; LOCK1 hands the memory to port 1
  // whenever it asks; ARB favours port 0 unless port 1 has waited MAX_WAIT.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n) begin
      if (state_q == S_LOCK1) begin
        gnt1 = req1;
      end else if (req1 && (!req0 || wait1_q == WAIT_W'(MAX_WAIT))) begin
        gnt1 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end
    end
  end

  assign stall0 = req0 & ~gnt0;

  // Memory command mux: all-zero when idle.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = 32'b0;
    mem_wd = 32'b0;
    mem_be = 4'b0;
    if (gnt0) begin
      mem_we = we0 & ~ill0;
      mem_a  = addr0;
      mem_wd = wdata0;
      mem_be = be0;
    end else if (gnt1) begin
      mem_we = we1 & ~ill1;
      mem_a  = addr1;
      mem_wd = wdata1;
      mem_be = be1;
    end
  end

  // Response capture: reads of legal codes return the extracted lane, writes
  // and illegal requests return zero data.
  always_comb begin
    rvalid0_d = gnt0;
    rvalid1_d = gnt1;
    rerr0_d   = gnt0 & ill0;
    rerr1_d   = gnt1 & ill1;
    rdata0_d  = (gnt0 && !we0 && !ill0) ? load_ext(mem_rd, addr0[1:0], be0) : 32'b0;
    rdata1_d  = (gnt1 && !we1 && !ill1) ? load_ext(mem_rd, addr1[1:0], be1) : 32'b0;
  end

  assign lock_exit = (state_q == S_LOCK1) &&
                     (!lock1 || lock_cnt_q >= LOCK_W'(MAX_LOCK - 1));

  // FSM and counters. lock_cnt starts at 1 on entry because the ARB cycle
  // that granted port 1 is the first cycle of its ownership window.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      S_ARB: begin
        if (gnt1 && lock1 && MAX_LOCK > 1) begin
          state_d    = S_LOCK1;
          lock_cnt_d = LOCK_W'(1);
        end
      end
      default: begin
        if (lock_exit) begin
          state_d    = S_ARB;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end
    endcase

    wait1_d = wait1_q;
    if (!req1 || gnt1 || lock_exit) begin
      wait1_d = '0;
    end else if (wait1_q < WAIT_W'(MAX_WAIT)) begin
      wait1_d = wait1_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_ARB;
      wait1_q    <= '0;
      lock_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rerr0_q    <= 1'b0;
      rerr1_q    <= 1'b0;
      rdata0_q   <= 32'b0;
      rdata1_q   <= 32'b0;
    end else begin
      state_q    <= state_d;
      wait1_q    <= wait1_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rerr0_q    <= rerr0_d;
      rerr1_q    <= rerr1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rerr0     = rerr0_q;
  assign rerr1     = rerr1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int MAX_LOCK = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0, req1, we0, we1, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [3:0]  be0, be1;
  logic        gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1, stall0;
  logic [31:0] rdata0, rdata1;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic [3:0]  mem_be;
  logic        dbg_state;

  int checks = 0;
  int failures = 0;

  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];

  logic [31:0] mem[0:63];
  logic [31:0] ref_mem[0:63];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .be0(be0), .be1(be1), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rerr0(rerr0), .rerr1(rerr1),
    .stall0(stall0), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_be(mem_be), .mem_rd(mem_rd), .dbg_state(dbg_state)
  );

  // ---------------- memory and reference model ----------------
  function automatic logic [31:0] apply_write(input logic [31:0] old, input logic [1:0] a,
                                              input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    case (be)
      4'b1111: r = wd;
      4'b0001: r[8*a +: 8] = wd[7:0];
      4'b0011: r[16*a[1] +: 16] = wd[15:0];
      default: r = old;
    endcase
    return r;
  endfunction

  function automatic logic exp_illegal(input logic we, input logic [3:0] be, input logic [1:0] a);
    logic ok;
    case ({we, be})
      5'b0_1111, 5'b1_1111: ok = (a == 2'b00);
      5'b0_0001, 5'b0_1001, 5'b1_0001: ok = 1'b1;
      5'b0_0011, 5'b0_1011, 5'b1_0011: ok = (a[0] == 1'b0);
      default: ok = 1'b0;
    endcase
    return !ok;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] a,
                                           input logic [3:0] be);
    logic [31:0] sb, sh;
    sb = w >> (8 * a);
    sh = w >> (16 * a[1]);
    case (be)
      4'b1111: return w;
      4'b0001: return {24'h0, sb[7:0]};
      4'b1001: return {{24{sb[7]}}, sb[7:0]};
      4'b0011: return {16'h0, sh[15:0]};
      4'b1011: return {{16{sh[15]}}, sh[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[7:2]] = apply_write(mem[mem_a[7:2]], mem_a[1:0], mem_wd, mem_be);
  end

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int port, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
    logic        ill;
    logic [32:0] e;
    ill = exp_illegal(we, be, a[1:0]);
    if (ill) e = {1'b1, 32'h0};
    else if (we) begin
      ref_mem[a[7:2]] = apply_write(ref_mem[a[7:2]], a[1:0], wd, be);
      e = {1'b0, 32'h0};
    end else e = {1'b0, exp_load(ref_mem[a[7:2]], a[1:0], be)};
    if (port == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    check_eq("stall0", stall0, req0 & ~gnt0);
    check_eq("gnt_onehot", gnt0 & gnt1, 1'b0);
    if (rvalid0 === 1'b1) begin
      check_eq("rvalid0_expected", exp_q0.size() != 0, 1'b1);
      if (exp_q0.size() != 0) begin
        e = exp_q0.pop_front();
        check_eq("resp0", {rerr0, rdata0}, e);
      end
    end else check_eq("rerr0_idle", rerr0, 1'b0);
    if (rvalid1 === 1'b1) begin
      check_eq("rvalid1_expected", exp_q1.size() != 0, 1'b1);
      if (exp_q1.size() != 0) begin
        e = exp_q1.pop_front();
        check_eq("resp1", {rerr1, rdata1}, e);
      end
    end else check_eq("rerr1_idle", rerr1, 1'b0);
  end

  // ---------------- drivers ----------------
  task automatic tx(input int port, input logic we, input logic [31:0] a,
                    input logic [31:0] wd, input logic [3:0] be);
    int n;
    @(posedge clk); #1;
    if (port == 0) begin
      req0 = 1; we0 = we; addr0 = a; wdata0 = wd; be0 = be;
    end else begin
      req1 = 1; we1 = we; addr1 = a; wdata1 = wd; be1 = be; lock1 = 0;
    end
    n = 0;
    @(negedge clk);
    while (((port == 0) ? gnt0 : gnt1) !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("gnt_latency", n, 0);
    check_eq("mem_we", mem_we, we & ~exp_illegal(we, be, a[1:0]));
    check_eq("mem_a", mem_a, a);
    if (n < 20) push_exp(port, we, a, wd, be);
    @(posedge clk); #1;
    if (port == 0) req0 = 0; else req1 = 0;
  endtask

  // One cycle of both ports with fixed read commands and a known grant pattern.
  task automatic cyc(input logic r0, input logic r1, input logic l1,
                     input logic eg0, input logic eg1);
    @(posedge clk); #1;
    req0 = r0; req1 = r1; lock1 = l1;
    @(negedge clk);
    check_eq("cyc_gnt0", gnt0, eg0);
    check_eq("cyc_gnt1", gnt1, eg1);
    if (eg0) push_exp(0, we0, addr0, wdata0, be0);
    else if (eg1) push_exp(1, we1, addr1, wdata1, be1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] codes[8];
    codes = '{4'b1111, 4'b0001, 4'b1001, 4'b0011, 4'b1011, 4'b1001, 4'b0111, 4'b0000};
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
      ref_mem[i] = mem[i];
    end
    reset_n = 0;
    req0 = 1; req1 = 1; we0 = 1; we1 = 1; lock1 = 1;
    addr0 = 0; addr1 = 4; wdata0 = 32'h1234_5678; wdata1 = 32'h9ABC_DEF0;
    be0 = 4'b1111; be1 = 4'b1111;

    // reset: no grants, no writes, responses cleared
    repeat (2) @(negedge clk);
    check_eq("rst_gnt0", gnt0, 1'b0);
    check_eq("rst_gnt1", gnt1, 1'b0);
    check_eq("rst_mem_we", mem_we, 1'b0);
    check_eq("rst_rvalid", {rvalid0, rvalid1}, 2'b00);
    check_eq("rst_rdata", {rdata0, rdata1}, 64'h0);
    check_eq("rst_state", dbg_state, 1'b0);

    // first cycle out of reset: word write on port 0 granted immediately
    @(posedge clk); #1;
    reset_n = 1; req1 = 0; lock1 = 0;
    req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF; be0 = 4'b1111;
    @(negedge clk);
    check_eq("first_gnt0", gnt0, 1'b1);
    check_eq("first_mem_we", mem_we, 1'b1);
    check_eq("first_mem_wd", mem_wd, 32'hDEADBEEF);
    if (gnt0) push_exp(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
    @(posedge clk); #1;
    req0 = 0;

    tx(0, 0, 32'h10, 0, 4'b1111);                 // read back DEADBEEF

    // illegal write on port 1: memory untouched, error response
    tx(1, 1, 32'h20, 32'h5555_AAAA, 4'b1001);
    check_eq("illegal_mem_unchanged", mem[8], ref_mem[8]);
    tx(1, 0, 32'h20, 0, 4'b1111);

    // misaligned and sub-word loads
    tx(0, 1, 32'h10, 32'h8001_5678, 4'b1111);
    tx(0, 0, 32'h13, 0, 4'b1111);                 // misaligned word
    tx(0, 0, 32'h12, 0, 4'b1011);                 // FFFF8001
    tx(0, 0, 32'h12, 0, 4'b0011);
    tx(0, 0, 32'h13, 0, 4'b1001);
    tx(0, 0, 32'h13, 0, 4'b0001);
    tx(0, 0, 32'h11, 0, 4'b0011);                 // misaligned half
    tx(1, 1, 32'h16, 32'h0000_ABCD, 4'b0011);
    tx(1, 1, 32'h15, 32'h0000_0077, 4'b0001);
    tx(1, 0, 32'h14, 0, 4'b1111);

    // starvation: port 1 wins every fifth cycle
    we0 = 0; addr0 = 32'h10; be0 = 4'b1111;
    we1 = 0; addr1 = 32'h14; be1 = 4'b1111;
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, (i % 5) != 4, (i % 5) == 4);
    cyc(0, 0, 0, 0, 0);

    // lock: 8 consecutive port-1 grants, then port 0
    cyc(0, 1, 1, 0, 1);
    cyc(1, 1, 1, 0, 1);
    check_eq("lock_state", dbg_state, 1'b1);
    for (int i = 2; i < 8; i++) cyc(1, 1, 1, 0, 1);
    cyc(1, 1, 1, 1, 0);
    check_eq("lock_exit_state", dbg_state, 1'b0);
    cyc(0, 0, 0, 0, 0);

    // reset during LOCK1 abandons ownership
    cyc(0, 1, 1, 0, 1);
    cyc(1, 1, 1, 0, 1);
    cyc(1, 1, 1, 0, 1);
    @(posedge clk); #1;
    reset_n = 0;
    @(negedge clk);
    check_eq("midrst_gnt", {gnt0, gnt1}, 2'b00);
    @(posedge clk); #1;
    reset_n = 1;
    @(negedge clk);
    check_eq("midrst_state", dbg_state, 1'b0);
    check_eq("midrst_gnt", {gnt0, gnt1}, 2'b10);
    if (gnt0) push_exp(0, we0, addr0, wdata0, be0);
    cyc(0, 0, 0, 0, 0);

    // random single-port traffic, legal and illegal codes mixed
    for (int i = 0; i < 40; i++) begin
      tx($urandom_range(1, 0), 1'($urandom_range(1, 0)), 32'($urandom_range(255, 0)),
         $urandom, codes[$urandom_range(7, 0)]);
    end

    repeat (3) @(negedge clk);
    check_eq("exp_q0_drained", exp_q0.size(), 0);
    check_eq("exp_q1_drained", exp_q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: got no finish expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
